uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter among up to NUM_REQ byte producers. Each requester presents one byte with a request. The block grants requesters round-robin, latches the granted byte, and launches it with a one-cycle start pulse. It then tracks the transmitter's busy flag until the frame completes. It sits between the producers (command/status generators) and the uart transmit path.

---
 rtl/uart_tx_arbiter_pkg.sv | 17 +
 rtl/uart_tx_arbiter_if.sv | 37 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_pkg: shared types and defaults for the UART transmit arbiter.
//   arb_state_e  - arbiter FSM encoding
//   *_DEF        - default requester count, byte width and busy-rise timeout
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LAUNCH    = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } arb_state_e;

   localparam int NUM_REQ_DEF = 4;
   localparam int DATA_W_DEF  = 8;
   localparam int TIMEOUT_DEF = 1023;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: producer-side and transmitter-side signals of the arbiter.
//   req/req_data/req_last  - requester byte offers (req_data lane i at [i*DATA_W +: DATA_W])
//   ack                    - one-hot byte-taken pulse
//   tx_data/tx_start       - byte and launch pulse towards the transmitter
//   tx_busy                - transmitter frame in progress
//   grant_id/active/timeout_err - status
// slave modport: the arbiter. master modport: producers + transmitter.
interface uart_tx_arbiter_if
   import uart_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W  = DATA_W_DEF
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ-1:0]        ack;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_start;
   logic                      tx_busy;
   logic [ID_W-1:0]           grant_id;
   logic                      active;
   logic                      timeout_err;

   modport slave (
      input  req, req_data, req_last, tx_busy,
      output ack, tx_data, tx_start, grant_id, active, timeout_err
   );

   modport master (
      output req, req_data, req_last, tx_busy,
      input  ack, tx_data, tx_start, grant_id, active, timeout_err
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req    - request vector
//   ptr    - highest-priority index; search runs upward from here with wrap
//   winner - index of first set req at or after ptr
//   valid  - any req set
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [ID_W-1:0]    winner,
   output logic               valid
);

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         int idx;
         idx = (int'(ptr) + i) % NUM_REQ;
         if (!valid && req[idx]) begin
            valid  = 1'b1;
            winner = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte producers.
// Round-robin grant, latches the byte, pulses tx_start/ack for one cycle, then
// follows tx_busy until the frame ends (or times out waiting for it to rise).
//   clk, reset - clock, synchronous active-high reset
//   bus        - uart_tx_arbiter_if.slave (requests, transmitter, status)
// Optional build macro UART_ARB_LOCK_EN: packet lock; the grant stays with a
// requester until it sends a byte flagged with req_last.
//
// state       | meaning
// ------------+-------------------------------------------------------
// IDLE        | arbitrate; latch winner's byte on any request
// LAUNCH      | tx_start and ack high for this single cycle
// WAIT_BUSY   | wait for tx_busy to rise, bounded by TIMEOUT
// WAIT_DONE   | frame in progress, wait for tx_busy to fall
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   uart_tx_arbiter_if.slave  bus
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   localparam logic [1:0] IDLE      = S_IDLE;
   localparam logic [1:0] LAUNCH    = S_LAUNCH;
   localparam logic [1:0] WAIT_BUSY = S_WAIT_BUSY;
   localparam logic [1:0] WAIT_DONE = S_WAIT_DONE;

   logic [1:0]         state_q;
   logic [ID_W-1:0]    ptr_q;
   logic [ID_W-1:0]    grant_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [DATA_W-1:0]  data_q;
   logic [NUM_REQ-1:0] ack_q;
   logic               start_q;
   logic [ID_W-1:0]    winner;
   logic               win_valid;
   logic [ID_W-1:0]    next_ptr;
   logic               timeout_hit;

   rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
      .req    (bus.req),
      .ptr    (ptr_q),
      .winner (winner),
      .valid  (win_valid)
   );

   // Requester after the current grant, wrapping for non-power-of-two counts.
   assign next_ptr = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);

   // Counter stops at CNT_MAX; the FSM leaves WAIT_BUSY on that same cycle.
   assign timeout_hit = (state_q == WAIT_BUSY) && !bus.tx_busy && (cnt_q == CNT_MAX);

`ifdef UART_ARB_LOCK_EN
   logic last_q;
`else
   logic unused_last;
   assign unused_last = ^bus.req_last;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         ack_q   <= '0;
         start_q <= 1'b0;
`ifdef UART_ARB_LOCK_EN
         last_q  <= 1'b0;
`endif
      end else begin
         ack_q   <= '0;
         start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (win_valid) begin
                  grant_q        <= winner;
                  data_q         <= bus.req_data[int'(winner)*DATA_W +: DATA_W];
                  ack_q[winner]  <= 1'b1;
                  start_q        <= 1'b1;
`ifdef UART_ARB_LOCK_EN
                  last_q         <= bus.req_last[winner];
`endif
                  state_q        <= LAUNCH;
               end
            end
            LAUNCH: begin
               cnt_q   <= '0;
               state_q <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (bus.tx_busy) begin
                  state_q <= WAIT_DONE;
               end else if (cnt_q == CNT_MAX) begin
                  // Timeout always advances the pointer, which also drops any packet lock.
                  ptr_q   <= next_ptr;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            WAIT_DONE: begin
               if (!bus.tx_busy) begin
`ifdef UART_ARB_LOCK_EN
                  // Holding ptr on the granted requester makes rr_pick choose it
                  // again first; if it has dropped req the search simply moves on.
                  if (last_q) ptr_q <= next_ptr;
`else
                  ptr_q <= next_ptr;
`endif
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ack         = ack_q;
   assign bus.tx_start    = start_q;
   assign bus.tx_data     = data_q;
   assign bus.grant_id    = grant_q;
   assign bus.active      = (state_q != IDLE);
   assign bus.timeout_err = timeout_hit;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
   localparam int NR = 4;
   localparam int DW = 8;
   localparam int TO = 1023;
   localparam int FRAME = 10;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   logic tx_model_en = 1'b0;
   int   busy_left = 0;

   uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

   uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Transmitter model: busy rises in the LAUNCH cycle and stays high FRAME cycles.
   initial begin
      bus.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) bus.tx_busy = 1'b0;
         end
         if (tx_model_en && bus.tx_start === 1'b1) begin
            busy_left   = FRAME;
            bus.tx_busy = 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_start(input string tag, output int at);
      at = -1;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (bus.tx_start === 1'b1) begin
            at = cyc;
            break;
         end
      end
      total++;
      assert (at >= 0) else begin
         bad++;
         $error("FAIL %s observed=no_tx_start expected=tx_start", tag);
      end
   endtask

   task automatic wait_idle(input string tag);
      int ok;
      ok = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (bus.active === 1'b0) begin
            ok = 1;
            break;
         end
      end
      total++;
      assert (ok == 1) else begin
         bad++;
         $error("FAIL %s observed=active expected=idle", tag);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack"},      32'(bus.ack),         32'h0);
      chk({tag, "_start"},    32'(bus.tx_start),    32'h0);
      chk({tag, "_data"},     32'(bus.tx_data),     32'h0);
      chk({tag, "_grant"},    32'(bus.grant_id),    32'h0);
      chk({tag, "_active"},   32'(bus.active),      32'h0);
      chk({tag, "_timeout"},  32'(bus.timeout_err), 32'h0);
   endtask

   int at, prev_at, t0, first_hi, n_hi, act_at, act_after, n0;
   int exp_g[4];
   logic [7:0] exp_d[4];

   initial begin
      reset        = 1'b1;
      bus.req      = '0;
      bus.req_last = '0;
      bus.req_data = {8'hC3, 8'hB2, 8'hA1, 8'h55};
      tick(); tick();
      chk_all_zero("reset");
      reset = 1'b0;
      tx_model_en = 1'b1;
      tick();

      // Single requester: latency, one-cycle pulses, byte held through frame.
      t0 = cyc;
      bus.req = 4'b0001;
      wait_start("single_start", at);
      chk("single_latency", 32'(at - t0), 32'd1);
      chk("single_ack",     32'(bus.ack),      32'h1);
      chk("single_data",    32'(bus.tx_data),  32'h55);
      chk("single_grant",   32'(bus.grant_id), 32'd0);
      chk("single_active",  32'(bus.active),   32'd1);
      bus.req = 4'b0000;
      tick();
      chk("single_start_pulse", 32'(bus.tx_start), 32'd0);
      chk("single_ack_pulse",   32'(bus.ack),      32'd0);
      repeat (FRAME - 1) tick();
      chk("single_active_done_cycle", 32'(bus.active),  32'd1);
      chk("single_data_stable",       32'(bus.tx_data), 32'h55);
      tick();
      chk("single_active_idle",       32'(bus.active),  32'd0);

      // All four from reset: 0,1,2,3,0, each launch FRAME+2 after the previous.
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      bus.req = 4'b1111;
      prev_at = 0;
      for (int k = 0; k < 5; k++) begin
         wait_start("rr_start", at);
         chk("rr_grant", 32'(bus.grant_id), 32'(k % 4));
         chk("rr_ack",   32'(bus.ack),      32'(1 << (k % 4)));
         chk("rr_data",  32'(bus.tx_data),  32'(bus.req_data[(k % 4)*8 +: 8]) );
         if (k > 0) chk("rr_interval", 32'(at - prev_at), 32'(FRAME + 2));
         prev_at = at;
         if (k == 4) bus.req = 4'b0000;
      end
      wait_idle("rr_idle");

      // Timeout: ptr=1, requester 2 wins, busy never rises.
      tx_model_en = 1'b0;
      bus.req = 4'b0100;
      wait_start("to_start", at);
      chk("to_grant", 32'(bus.grant_id), 32'd2);
      bus.req = 4'b0000;
      first_hi = -1; n_hi = 0; act_at = -1; act_after = -1;
      for (int n = 0; n < TO + 20; n++) begin
         tick();
         if (bus.timeout_err === 1'b1) begin
            if (first_hi < 0) begin
               first_hi = cyc;
               act_at   = int'(bus.active);
            end
            n_hi++;
         end
         if (first_hi >= 0 && cyc == first_hi + 1) act_after = int'(bus.active);
      end
      chk("to_cycle",        32'(first_hi - at), 32'(TO + 1));
      chk("to_pulse_width",  32'(n_hi),          32'd1);
      chk("to_active_at",    32'(act_at),        32'd1);
      chk("to_active_after", 32'(act_after),     32'd0);
      // ptr advanced to 3: search 3,0,... picks 0 (unadvanced ptr would pick 2).
      tx_model_en = 1'b1;
      bus.req = 4'b0101;
      wait_start("to_ptr_start", at);
      chk("to_ptr_grant", 32'(bus.grant_id), 32'd0);
      bus.req = 4'b0000;
      wait_idle("to_ptr_idle");

      // Reset during WAIT_DONE, then restart on requester 2.
      bus.req_data = {8'hC3, 8'hB2, 8'hA1, 8'h5A};
      bus.req = 4'b0001;
      wait_start("rst_start", at);
      chk("rst_pre_data", 32'(bus.tx_data), 32'h5A);
      bus.req = 4'b0000;
      tick(); tick(); tick();
      chk("rst_pre_active", 32'(bus.active), 32'd1);
      reset = 1'b1;
      tick();
      chk_all_zero("rst_mid");
      reset = 1'b0;
      bus.req = 4'b0100;
      wait_start("rst_restart", at);
      chk("rst_restart_grant", 32'(bus.grant_id), 32'd2);
      chk("rst_restart_ack",   32'(bus.ack),      32'h4);
      chk("rst_restart_data",  32'(bus.tx_data),  32'hB2);
      bus.req = 4'b0000;
      wait_idle("rst_idle");

      // Packet of three bytes from requester 0 competing with requester 1.
`ifdef UART_ARB_LOCK_EN
      exp_g = '{0, 0, 0, 1};
      exp_d = '{8'h10, 8'h11, 8'h12, 8'h20};
`else
      exp_g = '{0, 1, 0, 1};
      exp_d = '{8'h10, 8'h20, 8'h11, 8'h20};
`endif
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      bus.req_data = {8'h00, 8'h00, 8'h20, 8'h10};
      bus.req_last = 4'b0000;
      bus.req      = 4'b0011;
      n0 = 0;
      for (int g = 0; g < 4; g++) begin
         wait_start("pkt_start", at);
         chk("pkt_grant", 32'(bus.grant_id), 32'(exp_g[g]));
         chk("pkt_data",  32'(bus.tx_data),  32'(exp_d[g]));
         if (exp_g[g] == 0) begin
            n0++;
            if (n0 == 1) bus.req_data[7:0] = 8'h11;
            if (n0 == 2) begin
               bus.req_data[7:0] = 8'h12;
               bus.req_last[0]   = 1'b1;
            end
            if (n0 == 3) begin
               bus.req[0]      = 1'b0;
               bus.req_last[0] = 1'b0;
            end
         end
      end
      bus.req = 4'b0000;
      wait_idle("pkt_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
